// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   - BaudW          : width of the baud divider input
//   - Bits5..Bits8   : data_bits_i codes (5..8 data bits)
//   - ParNone/ParEven/ParOdd/ParNoneAlt : parity_i codes
//   - tx_state_e     : transmitter FSM encoding (StParity exists only when
//                      UART_TX_PARITY_EN is defined)
//   - helper functions decoding the frame configuration
package uart_pkg;

  localparam int unsigned BaudW = 16;

  localparam logic [1:0] Bits5 = 2'b00;
  localparam logic [1:0] Bits6 = 2'b01;
  localparam logic [1:0] Bits7 = 2'b10;
  localparam logic [1:0] Bits8 = 2'b11;

  localparam logic [1:0] ParNone    = 2'b00;
  localparam logic [1:0] ParEven    = 2'b01;
  localparam logic [1:0] ParOdd     = 2'b10;
  localparam logic [1:0] ParNoneAlt = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

  // Index of the last data bit sent for a given length code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    logic [2:0] idx;
    case (data_bits)
      Bits5:   idx = 3'd4;
      Bits6:   idx = 3'd5;
      Bits7:   idx = 3'd6;
      Bits8:   idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // XOR of the data bits that will actually be shifted out.
  function automatic logic data_parity(input logic [7:0] data, input logic [1:0] data_bits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i <= int'(last_bit_idx(data_bits))) p = p ^ data[i];
    end
    return p;
  endfunction

  function automatic logic par_enabled(input logic [1:0] parity);
    logic en;
    case (parity)
      ParEven, ParOdd:     en = 1'b1;
      ParNone, ParNoneAlt: en = 1'b0;
      default:             en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic logic par_odd(input logic [1:0] parity);
    return parity == ParOdd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with separate entry count so all DEPTH slots are usable.
// Ports:
//   clk_i, rst_ni     : clock, async active-low reset (pointers/count only)
//   push_i, wdata_i   : write request; ignored while full
//   pop_i, rdata_o    : read request; rdata_o shows the head entry
//   full_o, empty_o   : occupancy flags
//   level_o           : entry count, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntDepth = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  always_comb begin
    full_o    = (r_count == CntDepth);
    empty_o   = (r_count == '0);
    level_o   = r_count;
    rdata_o   = r_mem[r_rd_ptr];
    w_push_ok = push_i && !full_o;
    w_pop_ok  = pop_i && !empty_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrOne;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CntOne;
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CntOne;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a TX byte queue.
// Optional feature: define UART_TX_PARITY_EN to compile in the parity bit;
// without it parity_i is ignored and every frame is sent without parity.
// Ports:
//   clk_i, rst_ni        : clock, async active-low reset
//   baud_div_i           : bit period minus one, in clk_i cycles
//   data_bits_i          : 00=5, 01=6, 10=7, 11=8 data bits
//   parity_i             : 00/11=none, 01=even, 10=odd
//   stop2_i              : 0=one stop bit, 1=two stop bits
//   we_i, data_i         : enqueue one byte per asserted cycle
//   stall_i              : holds off the start of a new frame
//   ovf_clr_i            : clears the sticky overflow flag
//   full_o/empty_o/level_o : queue status
//   busy_o               : a frame is in progress
//   overflow_o           : sticky, set by a write while full
//   tx_o                 : serial line, idles high
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [BaudW-1:0] baud_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic [1:0]       parity_i,
  input  logic             stop2_i,
  input  logic             we_i,
  input  logic [7:0]       data_i,
  input  logic             stall_i,
  input  logic             ovf_clr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             tx_o
);

  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_level;
  logic [7:0]                  w_fifo_rdata;
  logic                        w_tick;
  logic                        w_can_start;
  logic                        w_stop_done;
  logic                        w_pop;

  tx_state_e        r_state;
  logic [BaudW-1:0] r_baud_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_last_idx;
  logic             r_stop2;
  logic             r_stop_idx;
  logic             r_tx;
  logic             r_overflow;
`ifdef UART_TX_PARITY_EN
  logic             r_par_en;
  logic             r_par_bit;
`else
  logic             w_unused_parity;
  assign w_unused_parity = ^parity_i;
`endif

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (we_i),
    .wdata_i (data_i),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .level_o (w_fifo_level)
  );

  always_comb begin
    w_tick      = (r_baud_cnt == baud_div_i);
    w_can_start = !w_fifo_empty && !stall_i;
    // Last stop tick: second stop bit already running, or only one configured.
    w_stop_done = (r_state == StStop) && w_tick && (!r_stop2 || r_stop_idx);
    // Idle starts without waiting for a tick; STOP chains straight into START.
    w_pop       = w_can_start && ((r_state == StIdle) || w_stop_done);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= '0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
`endif
    end else if (w_pop) begin
      // Configuration is captured here and held for the whole frame.
      r_state    <= StStart;
      r_baud_cnt <= '0;
      r_shift    <= w_fifo_rdata;
      r_last_idx <= last_bit_idx(data_bits_i);
      r_stop2    <= stop2_i;
      r_tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= par_enabled(parity_i);
      r_par_bit  <= data_parity(w_fifo_rdata, data_bits_i) ^ par_odd(parity_i);
`endif
    end else begin
      r_baud_cnt <= ((r_state == StIdle) || w_tick) ? '0 : r_baud_cnt + 16'd1;
      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
        end
        StStart: begin
          if (w_tick) begin
            r_state   <= StData;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit_idx == r_last_idx) begin
              r_state    <= StStop;
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
              if (r_par_en) begin
                r_state <= StParity;
                r_tx    <= r_par_bit;
              end
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_tick) begin
            r_state    <= StStop;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
`endif
        StStop: begin
          if (w_stop_done) begin
            r_state <= StIdle;
            r_tx    <= 1'b1;
          end else if (w_tick) begin
            r_stop_idx <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else if (we_i && w_fifo_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    full_o     = w_fifo_full;
    empty_o    = w_fifo_empty;
    level_o    = LVL_W'(w_fifo_level);
    busy_o     = (r_state != StIdle);
    overflow_o = r_overflow;
    tx_o       = r_tx;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: table of single-frame vectors, directed corner
// sequences and a randomized phase, all checked against a frame-level model.
module tb_uart_tx_cfg;

  localparam int unsigned Depth = 4;
  localparam int unsigned LvlW  = $clog2(Depth) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     baud_div = 16'd0;
  logic [1:0]      data_bits = 2'b11;
  logic [1:0]      parity = 2'b00;
  logic            stop2 = 1'b0;
  logic            we = 1'b0;
  logic [7:0]      data = 8'h00;
  logic            stall = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            full;
  logic            empty;
  logic [LvlW-1:0] level;
  logic            busy;
  logic            overflow;
  logic            tx;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .FIFO_DEPTH (Depth),
    .LVL_W      (LvlW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .baud_div_i  (baud_div),
    .data_bits_i (data_bits),
    .parity_i    (parity),
    .stop2_i     (stop2),
    .we_i        (we),
    .data_i      (data),
    .stall_i     (stall),
    .ovf_clr_i   (ovf_clr),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level),
    .busy_o      (busy),
    .overflow_o  (overflow),
    .tx_o        (tx)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a byte queue plus the expected line level for every future
  // cycle. A frame is launched whenever the line has nothing left to send,
  // the queue is non-empty and stall is low.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic       m_wave[$];
  logic       m_tx   = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_pop;
  logic       m_push;
  logic       chk_en = 1'b0;

  function automatic void add_frame(input logic [7:0] b);
    int   d;
    int   nb;
    logic par;
    logic par_en;
    d      = int'(baud_div) + 1;
    nb     = 5 + int'(data_bits);
    par    = (parity == 2'b10);
    par_en = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en = (parity == 2'b01) || (parity == 2'b10);
`endif
    repeat (d) m_wave.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      par = par ^ b[i];
      repeat (d) m_wave.push_back(b[i]);
    end
    if (par_en) repeat (d) m_wave.push_back(par);
    repeat (stop2 ? 2 * d : d) m_wave.push_back(1'b1);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_q.delete();
      m_wave.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_pop  = (m_q.size() != 0) && !stall && (m_wave.size() == 0);
      m_push = we && (m_q.size() < Depth);
      if (we && !m_push) m_ovf = 1'b1;
      else if (ovf_clr)  m_ovf = 1'b0;
      if (m_pop)  add_frame(m_q.pop_front());
      if (m_push) m_q.push_back(data);
      if (m_wave.size() != 0) begin
        m_tx   = m_wave.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every cycle: all outputs against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("outputs{tx,busy,full,empty,ovf,level}",
            {tx, busy, full, empty, overflow, level},
            {m_tx, m_busy, (m_q.size() == Depth), (m_q.size() == 0), m_ovf,
             LvlW'(m_q.size())});
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_wave.size() != 0 || m_busy) && n < 3000) begin
      tick();
      n++;
    end
    check(name, (n < 3000), 1'b1);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Single-frame vectors: frame[j] is the line level during bit time j
  // (start bit first), nbits is the frame length in bit times.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] div;
    logic [1:0]  bits;
    logic [1:0]  par;
    logic        stop2;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [15:0] div, input logic [1:0] bits,
                                  input logic [1:0] par, input logic s2, input logic [7:0] d,
                                  input int nbits, input logic [11:0] frame);
    vec_t v;
    v.div   = div;
    v.bits  = bits;
    v.par   = par;
    v.stop2 = s2;
    v.data  = d;
    v.nbits = nbits;
    v.frame = frame;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int hits;
    baud_div  = v.div;
    data_bits = v.bits;
    parity    = v.par;
    stop2     = v.stop2;
    we        = 1'b1;
    data      = v.data;
    tick();
    we = 1'b0;
    check($sformatf("vec%0d_tx_before_start", idx), tx, 1'b1);
    for (int j = 0; j < v.nbits; j++) begin
      hits = 0;
      for (int c = 0; c <= int'(v.div); c++) begin
        tick();
        if (tx === v.frame[j]) hits++;
      end
      check($sformatf("vec%0d_bit%0d_cycles_ok", idx, j), hits, int'(v.div) + 1);
    end
    tick();
    check($sformatf("vec%0d_end_tx_busy", idx), {tx, busy}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         falls;
    int         cnt;
    logic       prev;
    logic [20:0] got;

    add_vec(16'd3, 2'b11, 2'b00, 1'b0, 8'hA5, 10, 12'h34A);  // 8N1
    add_vec(16'd0, 2'b00, 2'b11, 1'b0, 8'hF3,  7, 12'h066);  // 5N1, upper bits ignored
    add_vec(16'd1, 2'b01, 2'b00, 1'b1, 8'h2A,  9, 12'h1D4);  // 6N2
`ifdef UART_TX_PARITY_EN
    add_vec(16'd2, 2'b10, 2'b01, 1'b1, 8'h41, 11, 12'h682);  // 7E2
    add_vec(16'd2, 2'b10, 2'b10, 1'b0, 8'h41, 10, 12'h382);  // 7O1
`else
    add_vec(16'd2, 2'b10, 2'b01, 1'b0, 8'h41,  9, 12'h182);  // parity_i ignored
`endif

    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_tx", tx, 1'b1);
    check("reset_flags{busy,full,empty,ovf}", {busy, full, empty, overflow}, 4'b0010);
    check("reset_level", level, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Fill under stall, overflow, clear, then release exactly four frames.
    baud_div  = 16'd0;
    data_bits = 2'b11;
    parity    = 2'b00;
    stop2     = 1'b0;
    stall     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      we   = 1'b1;
      data = 8'hFF;
      tick();
      if (i == 3) check("full_after4{full,level,ovf}", {full, level, overflow}, {1'b1, 3'd4, 1'b0});
    end
    we = 1'b0;
    check("full_after5{full,level,ovf}", {full, level, overflow}, {1'b1, 3'd4, 1'b1});
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    stall = 1'b0;
    falls = 0;
    prev  = tx;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (prev === 1'b1 && tx === 1'b0) falls++;
      prev = tx;
    end
    check("full_drain_frames", falls, 4);
    check("full_drain_empty", empty, 1'b1);

    // Pop into START coincides with a write at full: write dropped.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      we   = 1'b1;
      data = 8'(8'h30 + i);
      tick();
    end
    stall = 1'b0;
    data  = 8'h5A;
    tick();
    we = 1'b0;
    check("simul{level,ovf,busy}", {level, overflow, busy}, {3'd3, 1'b1, 1'b1});
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    wait_idle("simul_drain");

    // Back-to-back 5N1 frames at one cycle per bit.
    data_bits = 2'b00;
    stall     = 1'b1;
    we        = 1'b1;
    data = 8'hF5; tick();
    data = 8'hEA; tick();
    data = 8'h1F; tick();
    we    = 1'b0;
    stall = 1'b0;
    cnt   = 0;
    for (int c = 0; c < 21; c++) begin
      tick();
      got[c] = tx;
      if (busy) cnt++;
    end
    check("b2b_busy_cycles", cnt, 21);
    check("b2b_wave", got, 21'h1FAA6A);
    tick();
    check("b2b_idle_after", {busy, tx}, 2'b01);

    // Reset in the middle of data bit 3 with another byte still queued.
    baud_div  = 16'd3;
    data_bits = 2'b11;
    we = 1'b1;
    data = 8'hA5; tick();
    data = 8'h3C; tick();
    we = 1'b0;
    repeat (17) tick();
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset{busy,empty,level}", {busy, empty, level}, {1'b0, 1'b1, 3'd0});
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("post_reset_line", {tx, busy}, 2'b10);

    // Config changed mid-frame only affects the next frame: 5N1 at 2 cycles/bit.
    baud_div  = 16'd1;
    data_bits = 2'b00;
    parity    = 2'b00;
    stop2     = 1'b0;
    we        = 1'b1;
    data      = 8'hFF;
    tick();
    we  = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 3) begin
        data_bits = 2'b11;
        parity    = 2'b01;
        stop2     = 1'b1;
      end
      if (busy) cnt++;
    end
    check("cfg_midframe_len", cnt, 14);
    parity = 2'b00;
    stop2  = 1'b0;
    wait_idle("cfg_drain");

    // Randomized traffic; baud changes only while idle.
    for (int p = 0; p < 10; p++) begin
      baud_div = 16'($urandom_range(0, 3));
      for (int c = 0; c < 250; c++) begin
        we      = ($urandom_range(0, 3) == 0);
        data    = 8'($urandom);
        stall   = ($urandom_range(0, 7) == 0);
        ovf_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) begin
          data_bits = 2'($urandom_range(0, 3));
          parity    = 2'($urandom_range(0, 3));
          stop2     = 1'($urandom_range(0, 1));
        end
        tick();
      end
      we      = 1'b0;
      stall   = 1'b0;
      ovf_clr = 1'b0;
      wait_idle($sformatf("rand%0d_drain", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
